// File: rtl/calc_lock_sched_if.sv
// Request/response bundle between requesters, the lock sequencer and the result consumer.
// The requester/consumer side uses the master modport; the sequencer uses the slave modport.
interface calc_lock_sched_if #(
    parameter int NREQ = 2,
    parameter int DW   = 32
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // A transfer happens on a rising clock edge where valid and ready are both high.
    // valid must not depend on ready. The sequencer holds rsp_valid and its payload stable until accepted.
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_a, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/calc_lock_sched.sv
// Round-robin sequencer that shares one key-locked constant multiplier among NREQ requesters.
// The serial key must be loaded completely before any request is granted.
module calc_lock_sched #(
    parameter int              NREQ       = 2,
    parameter int              DW         = 32,
    parameter int              KW         = 33,
    parameter int              MUL_LAT    = 2,
    parameter logic [DW-1:0]   CONST_MASK = 32'hE9AA4AB3
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               key_valid,
    input  logic               key_bit,
    input  logic               key_clear,
    output logic               key_loaded,
    output logic               ap_idle,
    output logic [1:0]         dbg_state,
    calc_lock_sched_if.slave   bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(KW + 1);
    localparam int LW  = $clog2(MUL_LAT + 1);
    localparam int PD  = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

    typedef enum logic [1:0] {
        S_KEY_LOAD = 2'd0,
        S_IDLE     = 2'd1,
        S_BUSY     = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        key_q, key_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 key_loaded_q, key_loaded_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [DW-1:0]        rsp_data_q, rsp_data_d;
    logic [LW-1:0]        lat_q, lat_d;
    logic [PD-1:0][DW-1:0] pipe_q, pipe_d;

    logic                 hi_found, lo_found, any_req, can_grant;
    logic [IDW-1:0]       hi_sel, lo_sel, gnt_idx;
    logic [NREQ-1:0]      gnt_oh;
    logic [DW-1:0]        sel_a, mask_w, prod_in;

    assign mask_w  = CONST_MASK ^ key_q[DW:1];
    assign prod_in = sel_a * mask_w;

    // Search above the pointer first (hi), then wrap to the lowest index at or below it (lo).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (i > int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_sel   = IDW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_sel   = IDW'(i);
                end
            end
        end
        any_req = hi_found | lo_found;
        gnt_idx = hi_found ? hi_sel : lo_sel;
        sel_a   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) sel_a = bus.req_a[i*DW +: DW];
        end
        can_grant = (state_q == S_IDLE) && any_req && !key_clear;
        gnt_oh    = '0;
        if (can_grant) gnt_oh[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        cnt_d        = cnt_q;
        key_loaded_d = key_loaded_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        lat_d        = lat_q;
        pipe_d       = pipe_q;
        // The product for the granted operand enters the pipe at grant, freezing the mask for the op.
        pipe_d[0]    = prod_in;
        for (int k = 1; k < PD; k++) pipe_d[k] = pipe_q[k-1];

        if (key_clear) begin
            state_d      = S_KEY_LOAD;
            key_d        = '0;
            cnt_d        = '0;
            key_loaded_d = 1'b0;
        end else begin
            case (state_q)
                S_KEY_LOAD: begin
                    if (key_valid) begin
                        key_d[cnt_q] = key_bit;
                        cnt_d        = cnt_q + 1'b1;
                        if (cnt_q == CW'(KW - 1)) begin
                            key_loaded_d = 1'b1;
                            state_d      = S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (can_grant) begin
                        rr_ptr_d = gnt_idx;
                        rsp_id_d = gnt_idx;
                        if (MUL_LAT == 1) begin
                            rsp_data_d = prod_in;
                            state_d    = S_RESP;
                        end else begin
                            lat_d   = LW'(1);
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (lat_q == LW'(MUL_LAT - 1)) begin
                        rsp_data_d = pipe_q[PD-1];
                        state_d    = S_RESP;
                    end else begin
                        lat_d = lat_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) state_d = S_IDLE;
                end
                default: state_d = S_KEY_LOAD;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= S_KEY_LOAD;
            key_q        <= '0;
            cnt_q        <= '0;
            key_loaded_q <= 1'b0;
            rr_ptr_q     <= IDW'(NREQ - 1);
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            lat_q        <= '0;
            pipe_q       <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            cnt_q        <= cnt_d;
            key_loaded_q <= key_loaded_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            lat_q        <= lat_d;
            pipe_q       <= pipe_d;
        end
    end

    assign bus.req_ready = gnt_oh;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign ap_idle       = (state_q == S_IDLE);
    assign key_loaded    = key_loaded_q;
    assign dbg_state     = state_q;
endmodule
